pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RISC-V core. It combines load-use stall detection with branch/jump redirect control. It drives PC write-enable, IF/ID write-enable, the PC source select and the IF/ID flushes. It is a state machine, so multi-cycle load stalls and the cycle after a redirect are handled explicitly. It also keeps saturating stall/flush performance counters.

Parameters:
LOAD_LAT, 1, load-use stall length in cycles (legal 1..7)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of EX instruction
id_rs1  in  5  rs1 of ID instruction
id_rs2  in  5  rs2 of ID instruction
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
branch  in  1  conditional branch in EX resolved taken
jump  in  2  00 none, 01 PC-relative jump (JAL), 10 register jump (JALR), 11 reserved
pc_write  out  1  PC register write enable
if_id_write  out  1  IF/ID register write enable
mux_to_pc  out  2  00 PC+4, 01 branch/JAL target, 10 JALR target
IF_Flush  out  1  zero the IF/ID register
ID_Flush  out  1  insert bubble into ID/EX
stall_cnt  out  CNT_W  cycles with pc_write=0
flush_cnt  out  CNT_W  redirect events

Behaviour:
- All state, including the counters, is updated on the rising clk edge. Outputs are combinational from the current state and inputs (0-cycle latency).
- Reset (synchronous): state=RUN, stall counter sc=0, stall_cnt=0, flush_cnt=0.
- While reset=1, outputs are forced to idle values: pc_write=1, if_id_write=1, mux_to_pc=00, IF_Flush=0, ID_Flush=0.
- Reset asserted in any state returns the block to RUN on the next edge. Any stall or redirect in progress is abandoned.
- Definitions:
  - hz = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - redir = branch | jump==01 | jump==10
- States: RUN, STALL, REDIR.
- RUN:
  - redir: mux_to_pc = 01 if branch or jump==01, else 10. IF_Flush=1, ID_Flush=1, pc_write=1, if_id_write=1. Next state REDIR; flush_cnt+1.
  - Priority: branch > jump. A redirect beats hz in the same cycle; the stalled consumer is flushed, and no stall or stall_cnt increment occurs.
  - else hz: pc_write=0, if_id_write=0, ID_Flush=1, IF_Flush=0, mux_to_pc=00, stall_cnt+1. If LOAD_LAT=1, stay in RUN; else go to STALL with sc=LOAD_LAT-2.
  - else: idle outputs, stay in RUN.
- STALL:
  - Outputs: pc_write=0, if_id_write=0, ID_Flush=1, mux_to_pc=00; stall_cnt+1.
  - branch and jump are ignored, because EX holds a bubble and ID is frozen.
  - sc==0: go to RUN; else sc-1.
  - Total freeze = LOAD_LAT consecutive cycles including the detect cycle.
- REDIR (exactly one cycle; ID holds a flushed bubble):
  - hz is ignored.
  - A redir is honoured exactly as in RUN and remains in REDIR, with flush_cnt+1.
  - Otherwise outputs are idle and the next state is RUN.
- jump==11 is treated as 00 in all states.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A register match with ex_rd==0 never stalls.

Test Plan:
- Reset: reset=1 for 2 cycles with branch=1 and hz inputs active -> pc_write=1, mux_to_pc=00, both flushes 0; after release, stall_cnt=0 and flush_cnt=0.
- Load-use, LOAD_LAT=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_write=0, if_id_write=0, ID_Flush=1 for exactly 1 cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Multi-cycle stall, LOAD_LAT=3: same hazard, with branch=1 pulsed in the 2nd cycle -> pc_write=0 for 3 consecutive cycles; the branch is ignored (mux_to_pc=00); stall_cnt=3, flush_cnt=0.
- Branch vs load-use: branch=1 and hz=1 in the same cycle -> mux_to_pc=01, IF_Flush=1, ID_Flush=1, pc_write=1. Next cycle, hz still asserted -> no stall. Result: flush_cnt=1, stall_cnt=0.
- Jumps: jump=10 -> mux_to_pc=10 with flushes. branch=1 with jump=10 -> mux_to_pc=01. jump=11 -> idle outputs.
- Back-to-back redirects and saturation: redir held 4 cycles -> flush each cycle, flush_cnt=4. With CNT_W=2 and 5 stalls -> stall_cnt holds at 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard sequencer.
// master = datapath side, slave = sequencer side.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             branch;
  logic [1:0]       jump;
  logic             pc_write;
  logic             if_id_write;
  logic [1:0]       mux_to_pc;
  logic             IF_Flush;
  logic             ID_Flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, branch, jump,
    input  pc_write, if_id_write, mux_to_pc, IF_Flush, ID_Flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, branch, jump,
    output pc_write, if_id_write, mux_to_pc, IF_Flush, ID_Flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/jump redirects and
// saturating stall/flush performance counters. Control outputs are combinational.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned SC_W = 3;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;
  localparam logic [SC_W-1:0]  SC_INIT = SC_W'((LOAD_LAT > 32'd1) ? (LOAD_LAT - 32'd2) : 32'd0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       hz_c, tgt_c, jalr_c, redir_c;
  logic       stall_inc_c, flush_inc_c;
  logic       pc_write_c, if_id_write_c, if_flush_c, id_flush_c;
  logic [1:0] mux_to_pc_c;

  // Load-use hazard and redirect decode; jump==11 decodes as no jump.
  always_comb begin
    hz_c = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
           ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
            (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    tgt_c   = bus.branch || (bus.jump == 2'b01);
    jalr_c  = bus.jump == 2'b10;
    redir_c = tgt_c || jalr_c;
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    sc_d          = sc_q;
    stall_inc_c   = 1'b0;
    flush_inc_c   = 1'b0;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    mux_to_pc_c   = PC_SEQ;
    if_flush_c    = 1'b0;
    id_flush_c    = 1'b0;

    if (!reset) begin
      unique case (state_q)
        S_RUN: begin
          if (redir_c) begin
            mux_to_pc_c = tgt_c ? PC_TARGET : PC_JALR;
            if_flush_c  = 1'b1;
            id_flush_c  = 1'b1;
            flush_inc_c = 1'b1;
            state_d     = S_REDIR;
          end else if (hz_c) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_flush_c    = 1'b1;
            stall_inc_c   = 1'b1;
            if (LOAD_LAT > 32'd1) begin
              state_d = S_STALL;
              sc_d    = SC_INIT;
            end
          end
        end
        // EX holds a bubble and ID is frozen, so redirects cannot arise here.
        S_STALL: begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_flush_c    = 1'b1;
          stall_inc_c   = 1'b1;
          if (sc_q == '0) begin
            state_d = S_RUN;
          end else begin
            sc_d = sc_q - SC_W'(1);
          end
        end
        // ID holds a flushed bubble, so a hazard against it is spurious.
        S_REDIR: begin
          if (redir_c) begin
            mux_to_pc_c = tgt_c ? PC_TARGET : PC_JALR;
            if_flush_c  = 1'b1;
            id_flush_c  = 1'b1;
            flush_inc_c = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end

    stall_cnt_d = (stall_inc_c && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc_c && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      sc_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.if_id_write = if_id_write_c;
  assign bus.mux_to_pc   = mux_to_pc_c;
  assign bus.IF_Flush    = if_flush_c;
  assign bus.ID_Flush    = id_flush_c;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3,
// CNT_W=2) driven by directed vectors; a negedge monitor checks each queued expectation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       mr [3];
  logic [4:0] rd [3];
  logic [4:0] rs1 [3];
  logic [4:0] rs2 [3];
  logic       u1 [3];
  logic       u2 [3];
  logic       br [3];
  logic [1:0] jp [3];

  pipeline_hazard_ctrl_if #(.CNT_W(16)) m0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) m1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  m2 ();

  assign m0.ex_mem_read = mr[0], m0.ex_rd = rd[0], m0.id_rs1 = rs1[0], m0.id_rs2 = rs2[0],
         m0.id_use_rs1 = u1[0], m0.id_use_rs2 = u2[0], m0.branch = br[0], m0.jump = jp[0];
  assign m1.ex_mem_read = mr[1], m1.ex_rd = rd[1], m1.id_rs1 = rs1[1], m1.id_rs2 = rs2[1],
         m1.id_use_rs1 = u1[1], m1.id_use_rs2 = u2[1], m1.branch = br[1], m1.jump = jp[1];
  assign m2.ex_mem_read = mr[2], m2.ex_rd = rd[2], m2.id_rs1 = rs1[2], m2.id_rs2 = rs2[2],
         m2.id_use_rs1 = u1[2], m2.id_use_rs2 = u2[2], m2.branch = br[2], m2.jump = jp[2];

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_l1  (.clk(clk), .reset(reset), .bus(m0.slave));
  pipeline_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_l3  (.clk(clk), .reset(reset), .bus(m1.slave));
  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(2))  u_sat (.clk(clk), .reset(reset), .bus(m2.slave));

  // Expected outputs packed as {pc_write, if_id_write, mux_to_pc, IF_Flush, ID_Flush}
  localparam logic [5:0] O_IDLE  = 6'b11_00_00;
  localparam logic [5:0] O_STALL = 6'b00_00_01;
  localparam logic [5:0] O_TGT   = 6'b11_01_11;
  localparam logic [5:0] O_JALR  = 6'b11_10_11;

  // Hazard input patterns
  localparam int HZ_NONE = 0;
  localparam int HZ_RS1  = 1;
  localparam int HZ_X0   = 2;
  localparam int HZ_RS2  = 3;
  localparam int HZ_NUSE = 4;

  typedef struct {
    int         d;
    string      nm;
    logic [5:0] o;
    int         sc;
    int         fc;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      mr[i] = 1'b0; rd[i] = 5'd0; rs1[i] = 5'd0; rs2[i] = 5'd0;
      u1[i] = 1'b0; u2[i] = 1'b0; br[i] = 1'b0; jp[i] = 2'b00;
    end
  endtask

  task automatic vec(input string nm, input int d, input logic rst, input int hp,
                     input logic b, input logic [1:0] j,
                     input logic [5:0] o, input int sc, input int fc);
    exp_t e;
    clear_inputs();
    reset = rst;
    case (hp)
      HZ_RS1:  begin mr[d] = 1'b1; rd[d] = 5'd5; rs1[d] = 5'd5; u1[d] = 1'b1; end
      HZ_X0:   begin mr[d] = 1'b1; rd[d] = 5'd0; rs1[d] = 5'd0; u1[d] = 1'b1; end
      HZ_RS2:  begin mr[d] = 1'b1; rd[d] = 5'd7; rs1[d] = 5'd3; u1[d] = 1'b1;
                     rs2[d] = 5'd7; u2[d] = 1'b1; end
      HZ_NUSE: begin mr[d] = 1'b1; rd[d] = 5'd7; rs1[d] = 5'd7; rs2[d] = 5'd7; end
      default: ;
    endcase
    br[d] = b;
    jp[d] = j;
    e.d = d; e.nm = nm; e.o = o; e.sc = sc; e.fc = fc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [5:0]  ao;
      logic [31:0] as, af;
      e = q.pop_front();
      case (e.d)
        0: begin
          ao = {m0.pc_write, m0.if_id_write, m0.mux_to_pc, m0.IF_Flush, m0.ID_Flush};
          as = 32'(m0.stall_cnt); af = 32'(m0.flush_cnt);
        end
        1: begin
          ao = {m1.pc_write, m1.if_id_write, m1.mux_to_pc, m1.IF_Flush, m1.ID_Flush};
          as = 32'(m1.stall_cnt); af = 32'(m1.flush_cnt);
        end
        default: begin
          ao = {m2.pc_write, m2.if_id_write, m2.mux_to_pc, m2.IF_Flush, m2.ID_Flush};
          as = 32'(m2.stall_cnt); af = 32'(m2.flush_cnt);
        end
      endcase
      n_vec++;
      if (ao !== e.o || as !== 32'(e.sc) || af !== 32'(e.fc)) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got out=%b stall_cnt=%0d flush_cnt=%0d, want out=%b stall_cnt=%0d flush_cnt=%0d",
                 e.nm, e.d, ao, as, af, e.o, e.sc, e.fc);
      end
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset forces idle outputs even with branch and hazard active
    vec("rst_a", 0, 1'b1, HZ_RS1, 1'b1, 2'b00, O_IDLE, 0, 0);
    vec("rst_b", 0, 1'b1, HZ_RS1, 1'b1, 2'b00, O_IDLE, 0, 0);

    // LOAD_LAT=1 instance
    vec("lu_stall",     0, 1'b0, HZ_RS1,  1'b0, 2'b00, O_STALL, 0, 0);
    vec("lu_release",   0, 1'b0, HZ_NONE, 1'b0, 2'b00, O_IDLE,  1, 0);
    vec("lu_x0",        0, 1'b0, HZ_X0,   1'b0, 2'b00, O_IDLE,  1, 0);
    vec("lu_rs2",       0, 1'b0, HZ_RS2,  1'b0, 2'b00, O_STALL, 1, 0);
    vec("lu_nouse",     0, 1'b0, HZ_NUSE, 1'b0, 2'b00, O_IDLE,  2, 0);
    vec("br_over_hz",   0, 1'b0, HZ_RS1,  1'b1, 2'b00, O_TGT,   2, 0);
    vec("redir_hz_ign", 0, 1'b0, HZ_RS1,  1'b0, 2'b00, O_IDLE,  2, 1);
    vec("jalr",         0, 1'b0, HZ_NONE, 1'b0, 2'b10, O_JALR,  2, 1);
    vec("br_gt_jalr",   0, 1'b0, HZ_NONE, 1'b1, 2'b10, O_TGT,   2, 2);
    vec("j11_redir",    0, 1'b0, HZ_NONE, 1'b0, 2'b11, O_IDLE,  2, 3);
    vec("j11_run",      0, 1'b0, HZ_NONE, 1'b0, 2'b11, O_IDLE,  2, 3);
    vec("jal",          0, 1'b0, HZ_NONE, 1'b0, 2'b01, O_TGT,   2, 3);
    vec("jal_after",    0, 1'b0, HZ_NONE, 1'b0, 2'b00, O_IDLE,  2, 4);
    for (int i = 0; i < 4; i++)
      vec("b2b_branch", 0, 1'b0, HZ_NONE, 1'b1, 2'b00, O_TGT,   2, 4 + i);
    vec("b2b_after",    0, 1'b0, HZ_NONE, 1'b0, 2'b00, O_IDLE,  2, 8);
    vec("j11_hz",       0, 1'b0, HZ_RS1,  1'b0, 2'b11, O_STALL, 2, 8);
    vec("l1_final",     0, 1'b0, HZ_NONE, 1'b0, 2'b00, O_IDLE,  3, 8);

    // CNT_W=2 instance: counters saturate at 3
    for (int i = 0; i < 5; i++)
      vec("sat_stall",  2, 1'b0, HZ_RS1,  1'b0, 2'b00, O_STALL, (i > 3) ? 3 : i, 0);
    for (int i = 0; i < 4; i++)
      vec("sat_flush",  2, 1'b0, HZ_NONE, 1'b1, 2'b00, O_TGT,   3, i);
    vec("sat_final",    2, 1'b0, HZ_NONE, 1'b0, 2'b00, O_IDLE,  3, 3);

    // LOAD_LAT=3 instance: 3-cycle freeze, branch ignored while stalled
    vec("ms_detect",    1, 1'b0, HZ_RS1,  1'b0, 2'b00, O_STALL, 0, 0);
    vec("ms_br_ign",    1, 1'b0, HZ_RS1,  1'b1, 2'b00, O_STALL, 1, 0);
    vec("ms_last",      1, 1'b0, HZ_RS1,  1'b0, 2'b00, O_STALL, 2, 0);
    vec("ms_release",   1, 1'b0, HZ_NONE, 1'b0, 2'b00, O_IDLE,  3, 0);
    vec("ms_detect2",   1, 1'b0, HZ_RS1,  1'b0, 2'b00, O_STALL, 3, 0);
    vec("ms_rst",       1, 1'b1, HZ_RS1,  1'b0, 2'b01, O_IDLE,  4, 0);
    vec("ms_post_rst",  1, 1'b0, HZ_NONE, 1'b0, 2'b00, O_IDLE,  0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
